// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        A_IDLE = 2'd0,
        A_GNT0 = 2'd1,
        A_GNT1 = 2'd2
    } arb_state_t;

    // Bits needed to hold 0..maxout inclusive.
    function automatic int cnt_width(input int maxout);
        return (maxout < 1) ? 1 : $clog2(maxout + 1);
    endfunction

endpackage

// File: rtl/wb_outst_cnt.sv
// Outstanding-strobe counter: saturating up/down count with synchronous clear.
// Latency: count updates on the clock edge after inc/dec/clr; flags are combinational from the count.
// Backpressure: inc is ignored when full, dec is ignored when empty; clr wins over both.
//
// Ports: clk_i/rst_i clock and async active-high reset; clr, inc, dec controls;
//        full (count == MAX) and empty (count == 0) flags.
module wb_outst_cnt #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    logic [W-1:0] cnt;
    logic         inc_ok;
    logic         dec_ok;

    assign full   = (cnt == W'(MAX));
    assign empty  = (cnt == '0);
    assign inc_ok = inc & ~full;
    assign dec_ok = dec & ~empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc_ok && !dec_ok) begin
            cnt <= cnt + W'(1);
        end else if (dec_ok && !inc_ok) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave pipelined Wishbone arbiter, grant held for the whole cyc, round-robin on ties.
// Latency: grant one cycle after cyc is seen in idle; data path is combinational passthrough.
// Backpressure: owner stalls on s_stall or when MAXOUT strobes are unacked; non-owner always stalled.
//
// Ports: clk_i/rst_i clock and async active-high reset; m0_*/m1_* master-side Wishbone
//        (cyc/stb/we/adr/dat_i/sel in, stall/ack/dat_o out); s_* slave-side Wishbone;
//        grant one-hot current owner (2'b00 when idle).
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter  int AWIDTH = 32,
    parameter  int DWIDTH = 32,
    parameter  int MAXOUT = 4,
    localparam int SELW   = DWIDTH / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_cyc,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic [AWIDTH-1:0] m0_adr,
    input  logic [DWIDTH-1:0] m0_dat_i,
    input  logic [SELW-1:0]   m0_sel,
    output logic              m0_stall,
    output logic              m0_ack,
    output logic [DWIDTH-1:0] m0_dat_o,

    input  logic              m1_cyc,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic [AWIDTH-1:0] m1_adr,
    input  logic [DWIDTH-1:0] m1_dat_i,
    input  logic [SELW-1:0]   m1_sel,
    output logic              m1_stall,
    output logic              m1_ack,
    output logic [DWIDTH-1:0] m1_dat_o,

    output logic              s_cyc,
    output logic              s_stb,
    output logic              s_we,
    output logic [AWIDTH-1:0] s_adr,
    output logic [DWIDTH-1:0] s_dat_o,
    output logic [SELW-1:0]   s_sel,
    input  logic              s_stall,
    input  logic              s_ack,
    input  logic [DWIDTH-1:0] s_dat_i,

    output logic [1:0]        grant
);

    localparam int CW = cnt_width(MAXOUT);

    arb_state_t state, state_d;
    logic       last, last_d;   // 1 = m1 owned the bus most recently
    logic       cnt_full;
    logic       cnt_empty;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       cnt_dec;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= A_IDLE;
            last  <= 1'b1;      // so m0 wins the first tie
        end else begin
            state <= state_d;
            last  <= last_d;
        end
    end

    always_comb begin
        state_d  = state;
        last_d   = last;
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_o  = '0;
        s_sel    = '0;
        m0_stall = 1'b1;
        m0_ack   = 1'b0;
        m0_dat_o = '0;
        m1_stall = 1'b1;
        m1_ack   = 1'b0;
        m1_dat_o = '0;

        case (state)
            A_IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_d = last ? A_GNT0 : A_GNT1;
                end else if (m0_cyc) begin
                    state_d = A_GNT0;
                end else if (m1_cyc) begin
                    state_d = A_GNT1;
                end
            end
            A_GNT0: begin
                last_d   = 1'b0;
                s_cyc    = m0_cyc;
                s_stb    = m0_stb & ~cnt_full;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_dat_o  = m0_dat_i;
                s_sel    = m0_sel;
                m0_stall = s_stall | cnt_full;
                m0_ack   = s_ack & ~cnt_empty;  // acks with nothing pending are dropped
                m0_dat_o = s_dat_i;
                if (!m0_cyc) begin
                    state_d = A_IDLE;
                end
            end
            A_GNT1: begin
                last_d   = 1'b1;
                s_cyc    = m1_cyc;
                s_stb    = m1_stb & ~cnt_full;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_dat_o  = m1_dat_i;
                s_sel    = m1_sel;
                m1_stall = s_stall | cnt_full;
                m1_ack   = s_ack & ~cnt_empty;
                m1_dat_o = s_dat_i;
                if (!m1_cyc) begin
                    state_d = A_IDLE;
                end
            end
            default: begin
                state_d = A_IDLE;
            end
        endcase
    end

    // s_cyc low covers both idle and an owner dropping cyc; the latter aborts
    // any pending strobes, so the count is forced back to zero.
    assign cnt_clr = ~s_cyc;
    assign cnt_inc = s_stb & ~s_stall;
    assign cnt_dec = m0_ack | m1_ack;

    wb_outst_cnt #(
        .MAX (MAXOUT),
        .W   (CW)
    ) u_outst (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .dec   (cnt_dec),
        .full  (cnt_full),
        .empty (cnt_empty)
    );

    assign grant = {state == A_GNT1, state == A_GNT0};

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: single master, tie-break, outstanding limit,
// abort with late acks, spurious ack, asynchronous reset mid-grant.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units after it.
module tb_wb_arbiter2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_cyc, m0_stb, m0_we;
    logic [31:0] m0_adr, m0_dat_i;
    logic [3:0]  m0_sel;
    logic        m0_stall, m0_ack;
    logic [31:0] m0_dat_o;
    logic        m1_cyc, m1_stb, m1_we;
    logic [31:0] m1_adr, m1_dat_i;
    logic [3:0]  m1_sel;
    logic        m1_stall, m1_ack;
    logic [31:0] m1_dat_o;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_dat_o;
    logic [3:0]  s_sel;
    logic        s_stall, s_ack;
    logic [31:0] s_dat_i;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    wb_arbiter2 #(.AWIDTH(32), .DWIDTH(32), .MAXOUT(4)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .m0_cyc   (m0_cyc),
        .m0_stb   (m0_stb),
        .m0_we    (m0_we),
        .m0_adr   (m0_adr),
        .m0_dat_i (m0_dat_i),
        .m0_sel   (m0_sel),
        .m0_stall (m0_stall),
        .m0_ack   (m0_ack),
        .m0_dat_o (m0_dat_o),
        .m1_cyc   (m1_cyc),
        .m1_stb   (m1_stb),
        .m1_we    (m1_we),
        .m1_adr   (m1_adr),
        .m1_dat_i (m1_dat_i),
        .m1_sel   (m1_sel),
        .m1_stall (m1_stall),
        .m1_ack   (m1_ack),
        .m1_dat_o (m1_dat_o),
        .s_cyc    (s_cyc),
        .s_stb    (s_stb),
        .s_we     (s_we),
        .s_adr    (s_adr),
        .s_dat_o  (s_dat_o),
        .s_sel    (s_sel),
        .s_stall  (s_stall),
        .s_ack    (s_ack),
        .s_dat_i  (s_dat_i),
        .grant    (grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [31:0] exp_adr;
        logic [31:0] exp_dat;

        rst_i    = 1'b1;
        m0_cyc   = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
        m0_adr   = 32'h0; m0_dat_i = 32'h1111_0000; m0_sel = 4'hF;
        m1_cyc   = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
        m1_adr   = 32'h0; m1_dat_i = 32'h2222_0000; m1_sel = 4'hF;
        s_stall  = 1'b0; s_ack = 1'b0; s_dat_i = 32'h5A5A_5A5A;

        // Reset state
        #3;
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_cyc", s_cyc, 1'b0);
        chk("rst_s_stb", s_stb, 1'b0);
        chk("rst_s_adr", s_adr, 32'h0);
        chk("rst_m0_stall", m0_stall, 1'b1);
        chk("rst_m1_stall", m1_stall, 1'b1);
        chk("rst_m0_dat_o", m0_dat_o, 32'h0);
        nxt(); nxt();
        rst_i = 1'b0;

        // ---- Single master: 4 pipelined reads, 1-cycle ack latency ----
        nxt();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h100;
        #1;
        chk("t1_idle_grant", grant, 2'b00);
        chk("t1_idle_stall", m0_stall, 1'b1);
        chk("t1_idle_s_cyc", s_cyc, 1'b0);
        nxt(); #1;
        chk("t1_grant", grant, 2'b01);
        chk("t1_s_stb", s_stb, 1'b1);
        chk("t1_s_adr", s_adr, 32'h100);
        chk("t1_stall", m0_stall, 1'b0);
        for (int i = 0; i < 4; i++) begin
            nxt();
            if (i < 3) begin
                m0_adr = 32'h104 + 32'(4 * i);
            end else begin
                m0_stb = 1'b0;
            end
            s_ack   = 1'b1;
            s_dat_i = 32'hA000_0000 + 32'(i);
            exp_adr = 32'h104 + 32'(4 * i);
            exp_dat = 32'hA000_0000 + 32'(i);
            #1;
            chk("t1_m0_ack", m0_ack, 1'b1);
            chk("t1_m0_dat", m0_dat_o, exp_dat);
            chk("t1_m1_ack", m1_ack, 1'b0);
            chk("t1_m1_dat", m1_dat_o, 32'h0);
            if (i < 3) begin
                chk("t1_s_adr_pipe", s_adr, exp_adr);
            end
        end
        // Spurious ack with nothing outstanding
        nxt();
        s_ack = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        #1;
        chk("spur_m0_ack", m0_ack, 1'b0);
        nxt();
        s_ack = 1'b0; m0_cyc = 1'b0;
        #1;
        chk("t1_rel_s_cyc", s_cyc, 1'b0);
        chk("t1_rel_grant", grant, 2'b01);
        nxt(); #1;
        chk("t1_idle_after", grant, 2'b00);

        // ---- Tie-break after a fresh reset ----
        rst_i = 1'b1;
        #1;
        chk("t2_rst_grant", grant, 2'b00);
        nxt();
        rst_i = 1'b0;
        nxt();
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        #1;
        chk("t2_idle", grant, 2'b00);
        nxt(); #1;
        chk("t2_tie_m0", grant, 2'b01);
        chk("t2_m1_stall", m1_stall, 1'b1);
        nxt();
        m0_cyc = 1'b0;
        #1;
        chk("t2_drop_s_cyc", s_cyc, 1'b0);
        nxt(); #1;
        chk("t2_gap_grant", grant, 2'b00);
        chk("t2_gap_s_cyc", s_cyc, 1'b0);
        nxt(); #1;
        chk("t2_m1_grant", grant, 2'b10);
        chk("t2_m1_s_cyc", s_cyc, 1'b1);
        nxt();
        m1_cyc = 1'b0;
        #1;
        nxt();
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        #1;
        chk("t2_idle2", grant, 2'b00);
        nxt(); #1;
        chk("t2_tie2_m0", grant, 2'b01);
        nxt();
        m0_cyc = 1'b0;
        #1;
        nxt();
        m1_stb = 1'b1; m1_adr = 32'h300;
        #1;
        chk("t3_idle", grant, 2'b00);

        // ---- Outstanding limit on m1, slave withholds acks ----
        for (int i = 0; i < 4; i++) begin
            nxt(); #1;
            chk("t3_accept_stall", m1_stall, 1'b0);
            chk("t3_accept_stb", s_stb, 1'b1);
        end
        nxt(); #1;
        chk("t3_full_stall", m1_stall, 1'b1);
        chk("t3_full_stb", s_stb, 1'b0);
        nxt(); #1;
        chk("t3_full_stall2", m1_stall, 1'b1);
        nxt();
        s_ack = 1'b1;
        #1;
        chk("t3_ack", m1_ack, 1'b1);
        chk("t3_ack_stall", m1_stall, 1'b1);
        nxt();
        s_ack = 1'b0;
        #1;
        chk("t3_fifth_stall", m1_stall, 1'b0);
        chk("t3_fifth_stb", s_stb, 1'b1);
        nxt(); #1;
        chk("t3_refull", m1_stall, 1'b1);
        nxt();
        s_ack = 1'b1; m1_stb = 1'b0;
        #1;
        chk("t3_ack2", m1_ack, 1'b1);

        // ---- Async reset while m1 owns the bus with 3 outstanding ----
        nxt();
        s_ack = 1'b0;
        #1;
        chk("t5_pre_grant", grant, 2'b10);
        #2;
        rst_i = 1'b1; s_ack = 1'b1;
        #1;
        chk("t5_grant", grant, 2'b00);
        chk("t5_s_cyc", s_cyc, 1'b0);
        chk("t5_m0_stall", m0_stall, 1'b1);
        chk("t5_m1_stall", m1_stall, 1'b1);
        chk("t5_m1_ack", m1_ack, 1'b0);
        nxt();
        rst_i = 1'b0; s_ack = 1'b0;
        #1;
        chk("t5_rel_idle", grant, 2'b00);
        nxt();
        s_ack = 1'b1;
        #1;
        chk("t5_m1_regrant", grant, 2'b10);
        chk("t5_cnt_clear", m1_ack, 1'b0);
        nxt();
        s_ack = 1'b0; m1_cyc = 1'b0;
        #1;

        // ---- Abort: m0 drops cyc with 2 outstanding ----
        nxt();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h400;
        #1;
        chk("t4_idle", grant, 2'b00);
        nxt();
        s_stall = 1'b1;
        #1;
        chk("t4_grant", grant, 2'b01);
        chk("t4_slave_stall", m0_stall, 1'b1);
        nxt();
        s_stall = 1'b0;
        #1;
        chk("t4_stall_free", m0_stall, 1'b0);
        nxt();
        m0_adr = 32'h404;
        #1;
        chk("t4_adr2", s_adr, 32'h404);
        nxt();
        m0_cyc = 1'b0; m0_stb = 1'b0;
        #1;
        chk("t4_abort_s_cyc", s_cyc, 1'b0);
        chk("t4_abort_s_stb", s_stb, 1'b0);
        nxt();
        s_ack = 1'b1;
        #1;
        chk("t4_late1_grant", grant, 2'b00);
        chk("t4_late1_m0_ack", m0_ack, 1'b0);
        nxt(); #1;
        chk("t4_late2_m0_ack", m0_ack, 1'b0);
        chk("t4_late2_m1_ack", m1_ack, 1'b0);
        nxt();
        s_ack = 1'b0; m1_cyc = 1'b1;
        #1;
        chk("t4_m1_idle", grant, 2'b00);
        nxt();
        s_ack = 1'b1;
        #1;
        chk("t4_m1_grant", grant, 2'b10);
        chk("t4_m1_cnt_zero", m1_ack, 1'b0);
        nxt();
        s_ack = 1'b0; m1_cyc = 1'b0;
        nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
